// File: rtl/contact_link_master.sv
// Host-side initiator for the contact-distributor byte link: sends command/payload, checks responses.
// Optional write-verify read-back enabled by defining CONTACT_LINK_VERIFY_EN.
module contact_link_master #(
  parameter int unsigned NContacts     = 136,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 CmdStart,
  input  logic [1:0]           CmdCode,
  input  logic [NContacts-1:0] Drive,
  input  logic [NContacts-1:0] ZMask,
  output logic [7:0]           Data,
  output logic                 DataValid,
  input  logic [7:0]           RxData,
  input  logic                 RxValid,
  output logic [NContacts-1:0] ReadBack,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Error,
  output logic [1:0]           ErrCode,
  output logic                 Mismatch
);

  localparam int unsigned G  = NContacts / 4;
  localparam int unsigned R  = NContacts / 8;
  localparam int unsigned TW = $clog2(TimeoutCycles + 1);
  localparam int unsigned IW = $clog2(G + 1);

  typedef enum logic [2:0] {StIdle, StSendCmd, StSendData, StWaitHdr, StRxData} state_e;

  state_e               state_q, state_d;
  logic [1:0]           code_q, code_d;
  logic                 verify_q, verify_d;
  logic [NContacts-1:0] drive_q, drive_d, zmask_q, zmask_d;
  logic [NContacts-1:0] readback_q, readback_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 done_q, done_d, error_q, error_d, mismatch_q, mismatch_d;
  logic [1:0]           err_code_q, err_code_d;

  function automatic logic [7:0] cmd_byte(input logic [1:0] code);
    case (code)
      2'd0:    return 8'h01;
      2'd1:    return 8'h20;
      2'd2:    return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    verify_d   = verify_q;
    drive_d    = drive_q;
    zmask_d    = zmask_q;
    readback_d = readback_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;
    mismatch_d = mismatch_q;
    Data       = 8'h00;
    DataValid  = 1'b0;

    case (state_q)
      StIdle: begin
        if (CmdStart) begin
          err_code_d = 2'd0;
          if (CmdCode == 2'd3) begin
            error_d    = 1'b1;
            err_code_d = 2'd3;
          end else begin
            code_d     = CmdCode;
            verify_d   = 1'b0;
            drive_d    = Drive;
            zmask_d    = ZMask;
            mismatch_d = 1'b0;
            state_d    = StSendCmd;
          end
        end
      end
      StSendCmd: begin
        Data      = cmd_byte(code_q);
        DataValid = 1'b1;
        idx_d     = '0;
        tmo_d     = '0;
        state_d   = (code_q == 2'd0) ? StSendData : StWaitHdr;
      end
      StSendData: begin
        Data      = {zmask_q[4*int'(idx_q) +: 4], drive_q[4*int'(idx_q) +: 4]};
        DataValid = 1'b1;
        idx_d     = idx_q + IW'(1);
        if (idx_q == IW'(G - 1)) begin
          idx_d   = '0;
          tmo_d   = '0;
          state_d = StWaitHdr;
        end
      end
      StWaitHdr: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (RxValid) begin
          tmo_d = '0;
          if (RxData == cmd_byte(code_q)) begin
            if (code_q == 2'd1) begin
              idx_d   = '0;
              state_d = StRxData;
            end else begin
`ifdef CONTACT_LINK_VERIFY_EN
              if (code_q == 2'd0) begin
                code_d   = 2'd1;
                verify_d = 1'b1;
                state_d  = StSendCmd;
              end else begin
                done_d  = 1'b1;
                state_d = StIdle;
              end
`else
              done_d  = 1'b1;
              state_d = StIdle;
`endif
            end
          end else begin
            error_d    = 1'b1;
            err_code_d = 2'd2;
            state_d    = StIdle;
          end
        end else if (tmo_q == TW'(TimeoutCycles - 1)) begin
          error_d    = 1'b1;
          err_code_d = 2'd1;
          state_d    = StIdle;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StRxData: begin
        if (RxValid) begin
          tmo_d = '0;
          readback_d[8*int'(idx_q) +: 8] = RxData;
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(R - 1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
            if (verify_q) begin
              mismatch_d = |((readback_d ^ drive_q) & ~zmask_q);
            end
          end
        end else if (tmo_q == TW'(TimeoutCycles - 1)) begin
          error_d    = 1'b1;
          err_code_d = 2'd1;
          state_d    = StIdle;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q    <= StIdle;
      code_q     <= 2'd0;
      verify_q   <= 1'b0;
      drive_q    <= '0;
      zmask_q    <= '0;
      readback_q <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'd0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      verify_q   <= verify_d;
      drive_q    <= drive_d;
      zmask_q    <= zmask_d;
      readback_q <= readback_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign ReadBack = readback_q;
  assign Busy     = (state_q != StIdle);
  assign Done     = done_q;
  assign Error    = error_q;
  assign ErrCode  = err_code_q;
`ifdef CONTACT_LINK_VERIFY_EN
  assign Mismatch = mismatch_q;
`else
  assign Mismatch = 1'b0;
  logic unused_mismatch;
  assign unused_mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_contact_link_master.sv
// Scoreboard bench for contact_link_master: stimulus pushes expected link events, monitor checks them.
module tb_contact_link_master;
  localparam int N = 136;
  localparam int T = 1024;
  localparam int G = N / 4;
  localparam int R = N / 8;

  logic         Clock = 1'b0;
  logic         ResetN = 1'b0;
  logic         CmdStart = 1'b0;
  logic [1:0]   CmdCode = 2'd0;
  logic [N-1:0] Drive = '0;
  logic [N-1:0] ZMask = '0;
  logic [7:0]   Data;
  logic         DataValid;
  logic [7:0]   RxData = 8'h00;
  logic         RxValid = 1'b0;
  logic [N-1:0] ReadBack;
  logic         Busy, Done, Error, Mismatch;
  logic [1:0]   ErrCode;

  contact_link_master #(.NContacts(N), .TimeoutCycles(T)) dut (
    .Clock(Clock), .ResetN(ResetN), .CmdStart(CmdStart), .CmdCode(CmdCode), .Drive(Drive),
    .ZMask(ZMask), .Data(Data), .DataValid(DataValid), .RxData(RxData), .RxValid(RxValid),
    .ReadBack(ReadBack), .Busy(Busy), .Done(Done), .Error(Error), .ErrCode(ErrCode),
    .Mismatch(Mismatch)
  );

  always #5 Clock = ~Clock;

  // kind: 0 = link byte, 1 = Done, 2 = Error
  typedef struct {int kind; int val; int cyc; int mm;} exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int c0;
  int gaps[8] = '{0, 3, 1, 7, 0, 12, 2, 5};

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input int kind, input int val, input int at, input int mm);
    exp_t x;
    x.kind = kind; x.val = val; x.cyc = at; x.mm = mm;
    q.push_back(x);
  endtask

  always @(negedge Clock) begin
    if (!DataValid && Data != 8'h00) begin
      n_chk++;
      $display("FAIL data_idle: got %0h expected 0 (cycle %0d)", Data, cyc);
    end
    if (Done && Error) begin
      n_chk++;
      $display("FAIL done_error_both: got 1 expected 0 (cycle %0d)", cyc);
    end
    if (DataValid || Done || Error) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_output: dv=%0d data=%0h done=%0d err=%0d expected none (cycle %0d)",
                 DataValid, Data, Done, Error, cyc);
      end else begin
        e = q.pop_front();
        chk("event_kind", DataValid ? 0 : (Done ? 1 : 2), e.kind);
        if (e.cyc >= 0) chk("event_cycle", cyc, e.cyc);
        if (e.kind == 0) chk("data", Data, e.val);
        else if (e.kind == 1) begin
          chk("done_busy", Busy, 0);
          chk("mismatch", Mismatch, e.mm);
        end else begin
          chk("err_code", ErrCode, e.val);
          chk("err_busy", Busy, 0);
        end
      end
    end
  end

  task automatic start(input logic [1:0] code, input logic [N-1:0] d, input logic [N-1:0] z,
                       input int npay);
    logic [7:0] cb;
    cb = (code == 0) ? 8'h01 : (code == 1) ? 8'h20 : 8'hFF;
    c0 = cyc;
    if (code == 3) push(2, 3, c0 + 1, 0);
    else push(0, cb, c0 + 1, 0);
    for (int k = 0; k < npay; k++) push(0, {z[4*k +: 4], d[4*k +: 4]}, c0 + 2 + k, 0);
    CmdStart = 1'b1; CmdCode = code; Drive = d; ZMask = z;
    tick();
    CmdStart = 1'b0;
    chk("busy_after_start", Busy, code != 3);
  endtask

  task automatic rx(input logic [7:0] b);
    RxValid = 1'b1; RxData = b;
    tick();
    RxValid = 1'b0; RxData = 8'h00;
  endtask

  task automatic read_resp(input logic [N-1:0] rb, input int gsel, input int mm);
    rx(8'h20);
    for (int j = 0; j < R; j++) begin
      repeat (gaps[(j + gsel) % 8]) tick();
      if (j == R - 1) push(1, 0, cyc + 1, mm);
      rx(rb[8*j +: 8]);
    end
  endtask

  task automatic write_ack(input logic [N-1:0] rb, input int mm);
`ifdef CONTACT_LINK_VERIFY_EN
    push(0, 8'h20, cyc + 1, 0);
    rx(8'h01);
    tick();
    read_resp(rb, 3, mm);
`else
    if (mm != 0 && rb != '0) $display("note: verify data unused");
    push(1, 0, cyc + 1, 0);
    rx(8'h01);
`endif
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while ((q.size() != 0 || Busy) && i < budget) begin
      tick();
      i++;
    end
    if (q.size() != 0 || Busy) begin
      n_chk++;
      $display("FAIL wait_timeout: pending=%0d busy=%0d expected 0/0", q.size(), Busy);
      q.delete();
    end
    tick();
  endtask

  logic [N-1:0] pat_d, pat_z, rb;

  initial begin
    pat_d = 136'h0123456789ABCDEFFEDCBA98765432105A;
    pat_z = 136'hF0E1D2C3B4A5968778695A4B3C2D1E0F3C;
    repeat (3) tick();
    @(negedge Clock);
    chk("rst_dv", DataValid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done_err", {Done, Error, ErrCode, Mismatch}, 0);
    chk("rst_readback", ReadBack, 0);
    tick();
    ResetN = 1'b1;
    tick();

    // Reset in the middle of the payload
    start(2'd0, pat_d, pat_z, 4);
    repeat (4) tick();
    ResetN = 1'b0;
    tick();
    ResetN = 1'b1;
    @(negedge Clock);
    chk("midrst_dv", DataValid, 0);
    chk("midrst_busy", Busy, 0);
    chk("midrst_pulses", {Done, Error}, 0);
    tick();
    wait_done(10);

    // Write all-ones drive, no high-Z
    start(2'd0, {N{1'b1}}, '0, G);
    repeat (G + 1) tick();
    write_ack({N{1'b1}}, 0);
    wait_done(200);

    // Write with mixed nibble pattern
    start(2'd0, pat_d, pat_z, G);
    repeat (G + 1) tick();
    write_ack(pat_d, 0);
    wait_done(200);

    // Read with gaps
    for (int j = 0; j < R; j++) rb[8*j +: 8] = 8'(j);
    rx(8'h20);
    start(2'd1, '0, '0, 0);
    tick();
    read_resp(rb, 0, 0);
    wait_done(200);
    chk("rb_low", ReadBack[7:0], 8'h00);
    chk("rb_high", ReadBack[135:128], 8'h10);
    chk("rb_full", ReadBack, rb);
    rx(8'h33);
    rx(8'h20);
    tick();
    chk("rb_stable", ReadBack, rb);

    // Board check with bad ack byte
    start(2'd2, '0, '0, 0);
    tick();
    push(2, 2, cyc + 1, 0);
    rx(8'h55);
    wait_done(20);
    repeat (3) tick();
    chk("errcode_hold", ErrCode, 2);

    // Board check with no response: timeout
    start(2'd2, '0, '0, 0);
    chk("errcode_clear", ErrCode, 0);
    push(2, 1, c0 + 2 + T, 0);
    wait_done(T + 50);

    // Byte on the expiry cycle wins over the timeout
    start(2'd2, '0, '0, 0);
    repeat (T) tick();
    push(1, 0, cyc + 1, 0);
    rx(8'hFF);
    wait_done(20);

    // Start strobes while busy are ignored
    for (int j = 0; j < R; j++) rb[8*j +: 8] = 8'(8'hFF - j);
    start(2'd1, '0, '0, 0);
    CmdCode = 2'd0; CmdStart = 1'b1;
    repeat (4) tick();
    CmdStart = 1'b0;
    read_resp(rb, 5, 0);
    wait_done(200);
    chk("rb_second", ReadBack, rb);

    // Reserved code
    start(2'd3, '0, '0, 0);
    wait_done(20);
    chk("errcode_reserved", ErrCode, 3);

`ifdef CONTACT_LINK_VERIFY_EN
    pat_d = {34{4'hA}};
    rb = pat_d;
    rb[5] = ~rb[5];
    start(2'd0, pat_d, '0, G);
    repeat (G + 1) tick();
    write_ack(rb, 1);
    wait_done(300);
    repeat (2) tick();
    chk("mismatch_hold", Mismatch, 1);
    start(2'd0, pat_d, '0, G);
    repeat (G + 1) tick();
    write_ack(pat_d, 0);
    wait_done(300);
    pat_z = '0;
    pat_z[5] = 1'b1;
    start(2'd0, pat_d, pat_z, G);
    repeat (G + 1) tick();
    write_ack(rb, 0);
    wait_done(300);
`endif

    repeat (5) tick();
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/contact_link_master.md
Name: contact_link_master

Overview:
- Host-side initiator for the contact-distributor byte link.
- Takes a command request from upper control logic and serialises it as command and payload bytes on Data/DataValid.
- Collects the distributor's response bytes on RxData/RxValid, then reports readback, completion or error.
- Sits between the USB/FIFO host bridge and the contact-distributor board.

Parameters:
- NContacts, 136, number of contacts; must be a multiple of 8.
- TimeoutCycles, 1024, maximum idle cycles between expected response bytes before error; minimum 2.

Ports:
- Clock  in  1  system clock; all logic on posedge.
- ResetN  in  1  synchronous active-low reset.
- CmdStart  in  1  one-cycle request strobe; sampled only in IDLE.
- CmdCode  in  2  0=write pattern, 1=read contacts, 2=board check, 3=reserved.
- Drive  in  NContacts  drive levels for write; sampled at accepted CmdStart.
- ZMask  in  NContacts  1=contact high-Z, for write; sampled at accepted CmdStart.
- Data  out  8  link byte to distributor.
- DataValid  out  1  Data qualifier; one byte per cycle while high.
- RxData  in  8  response byte from distributor.
- RxValid  in  1  RxData qualifier.
- ReadBack  out  NContacts  last contact levels read.
- Busy  out  1  high from accepted CmdStart until Done or Error pulse.
- Done  out  1  one-cycle success pulse.
- Error  out  1  one-cycle failure pulse.
- ErrCode  out  2  1=timeout, 2=bad header/ack byte, 3=reserved code; holds until next accepted command.
- Mismatch  out  1  write-verify result (see Optional Feature).

Behaviour:
- Reset (ResetN=0 at posedge): all outputs 0, state IDLE, counters 0. Applies mid-operation: DataValid drops at that edge and no Done/Error is emitted.
- Derived constants: G=NContacts/4 write bytes, R=NContacts/8 read bytes.
- IDLE:
  - CmdStart=1 with CmdCode 0..2: latch Drive/ZMask into a shift register, set Busy=1, go to SEND_CMD.
  - CmdCode=3: Error pulse with ErrCode=3 on the next cycle; Busy never asserts.
  - RxValid in IDLE is ignored.
- SEND_CMD: Data = 0x01 / 0x20 / 0xFF for codes 0/1/2; DataValid=1 for exactly one cycle.
  - Code 0 goes to SEND_DATA.
  - Codes 1 and 2 go to WAIT_HDR.
- SEND_DATA: G consecutive cycles with DataValid=1.
  - Byte k: bits[3:0]=Drive[4k+3:4k], bits[7:4]=ZMask[4k+3:4k]; k=0 is sent first.
  - After byte G-1, go to WAIT_HDR.
- Write timing: accepted CmdStart at cycle 0 gives the command byte at cycle 1 and payload at cycles 2..G+1; DataValid is continuous and Data is 0 whenever DataValid=0.
- WAIT_HDR: timeout counter clears on entry and on every RxValid; it counts otherwise.
  - RxValid with RxData equal to the sent command byte: code 0 or 2 gives Done next cycle and returns to IDLE; code 1 goes to RX_DATA.
  - RxValid with any other byte: Error with ErrCode=2.
  - Counter reaching TimeoutCycles: Error with ErrCode=1.
- RX_DATA: each RxValid byte j (j=0 first) is written to ReadBack[8j+7:8j].
  - Gaps are allowed; the timeout applies per byte.
  - After byte R-1: Done next cycle. ReadBack stays stable from then until the next read's first byte.
- Done and Error are mutually exclusive, each one cycle. Busy falls in the same cycle as the pulse.
- CmdStart while Busy: ignored, no queueing.
- RxValid in the same cycle as a timeout expiry: the byte wins and the timeout is discarded.
- Extra RxValid bytes after Done are ignored.

Optional Feature:
- Macro: CONTACT_LINK_VERIFY_EN.
- Defined: after a code-0 ack, the block auto-issues a read (0x20 plus R bytes, same rules) without dropping Busy. Done fires after readback.
  - Mismatch=1 if any contact with ZMask=0 reads back different from Drive; high-Z contacts are excluded.
  - Mismatch is valid with Done and held until the next accepted command.
  - Errors during the verify read are reported as normal Error pulses.
- Undefined: no verify read is issued; Mismatch is tied to 0.

Test Plan:
- Reset with ResetN=0 mid SEND_DATA -> next cycle DataValid=0, Busy=0, no Done/Error; subsequent command runs normally.
- Write (NContacts=136), Drive=all 1, ZMask=0 -> Data 0x01 then 34 bytes of 0x0F on consecutive cycles; inject RxData=0x01 -> Done one cycle later, Busy low.
- Read: inject 0x20 then 17 bytes 0x00..0x10 with random gaps < TimeoutCycles -> ReadBack[7:0]=0x00, ReadBack[135:128]=0x10, Done once.
- Board check, inject RxData=0x55 -> Error, ErrCode=2; repeat with no response -> Error, ErrCode=1 exactly TimeoutCycles cycles after the last clear.
- CmdStart pulses while Busy plus CmdCode=3 in IDLE -> no extra commands on Data; code 3 gives Error with ErrCode=3.
- With CONTACT_LINK_VERIFY_EN: write Drive=0xA..., ZMask=0; readback with bit 5 flipped -> Done with Mismatch=1; matching readback -> Mismatch=0.
